aquarius_vram: RTL and testbench
================================

Name: aquarius_vram

Overview:
- Screen/colour memory stage directly upstream of the video generator.
- Holds 1 KiB character RAM and 1 KiB colour RAM as single-port inferred blocks.
- Time-multiplexes them between the video fetch (priority) and CPU accesses through a one-deep request buffer, and returns registered `video_data`/`video_color`.
- Runs a clear sequence after reset so the first frame shows blank screen in the default colour.

Parameters:
- CLEAR_CHAR, 8'h20, char RAM fill value written during clear.
- CLEAR_COLOR, 8'h70, colour RAM fill value written during clear.
- RAM_AW, 10, address width of each RAM (depth 2^RAM_AW).

Ports:
- clk_sys  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  one-cycle strobe: video fetch at video_addr this cycle.
- video_addr  in  10  character cell address from video stage.
- video_data  out  8  registered char RAM read for last vid_req.
- video_color  out  8  registered colour RAM read for last vid_req.
- cpu_req  in  1  one-cycle strobe: CPU access request.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  11  bit10: 0=char RAM, 1=colour RAM; bits9:0 cell address.
- cpu_din  in  8  write data, sampled with cpu_req.
- cpu_dout  out  8  read data, valid when cpu_ack=1, held until next read completes.
- cpu_ack  out  1  one-cycle pulse on access completion.
- busy  out  1  high while clearing or a CPU request is pending/in flight.

Behaviour:
- Reset (async assert, sync release): video_data=CLEAR_CHAR, video_color=CLEAR_COLOR, cpu_dout=0, cpu_ack=0, busy=1, FSM=CLEAR, clear counter=0, pending buffer empty.
- FSM states: CLEAR, IDLE, CPU_GO, CPU_DONE.
- CLEAR:
  - Writes CLEAR_CHAR/CLEAR_COLOR to both RAMs at the counter address, one address per cycle.
  - Takes 1024 cycles; after address 1023 → IDLE.
  - vid_req during CLEAR: RAM port not used; video outputs return CLEAR values 2 cycles later.
- CPU buffer:
  - cpu_req with buffer empty captures we/addr/din.
  - cpu_req while buffer full or in flight is ignored (protocol error, no ack); CPU must wait for cpu_ack.
  - cpu_req during CLEAR is captured and served after CLEAR.
- Arbitration, per cycle in IDLE:
  - If vid_req=1, the RAM port serves video.
  - Else if buffer full → CPU_GO: RAM access performed at buffered address (write or read).
  - vid_req always wins; a blocked CPU access retries the next cycle with no limit on retries.
- CPU_GO → CPU_DONE:
  - Read data is registered into cpu_dout.
  - cpu_ack=1 for exactly one cycle.
  - Buffer cleared, then → IDLE.
  - Write ack latency is 2 cycles after grant; read ack is also 2 cycles after grant.
- vid_req in CPU_GO or CPU_DONE still has priority:
  - RAM access for video that cycle.
  - In CPU_GO the CPU access stalls (stays CPU_GO) and completes the next non-video cycle.
- Video latency: video_data/video_color update exactly 2 cycles after vid_req (RAM register + output register), then hold until next fetch.
- Same-cycle write/read collision: impossible by arbitration. A write one cycle before vid_req to the same address is visible to that fetch.
- busy = (FSM != IDLE) or buffer full.
- Reset asserted mid-access: access abandoned, no ack, clear sequence restarts from address 0.
- Address math: RAM_AW bits, no wrap-around logic needed; cpu_addr[10] selects RAM, and the unselected RAM is not written.

Test Plan:
- Reset release → busy=1 for 1024 cycles. Then vid_req with video_addr=10'h155 → video_data=8'h20, video_color=8'h70 two cycles later.
- After clear: CPU write addr=11'h005 din=8'h41, wait ack; CPU write addr=11'h405 din=8'h16; vid_req addr=5 → video_data=8'h41, video_color=8'h16 two cycles later.
- CPU read addr=11'h005 in IDLE with no vid_req → cpu_ack exactly 2 cycles after cpu_req+1 grant, cpu_dout=8'h41, one-cycle ack.
- cpu_req (read addr 11'h405) same cycle as vid_req, vid_req held high 3 cycles → video served each cycle, cpu_ack delayed 3 cycles, cpu_dout=8'h16.
- cpu_req write during CLEAR (cycle 100, addr 11'h3FF din=8'hAA) → served after clear completes, ack after clear; subsequent vid_req addr 10'h3FF returns 8'hAA (not overwritten by clear).
- Assert reset while in CPU_GO → no cpu_ack, busy=1; re-run clear; previously written cell reads back CLEAR_CHAR.

Source files
------------

// File: rtl/aquarius_vram.sv
// aquarius_vram: character/colour RAM shared between video fetch and CPU,
// with a post-reset clear sweep so the first frame is blank.
module aquarius_vram #(
   parameter logic [7:0] CLEAR_CHAR  = 8'h20,
   parameter logic [7:0] CLEAR_COLOR = 8'h70,
   parameter int         RAM_AW      = 10
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [RAM_AW-1:0] video_addr,
   output logic [7:0]        video_data,
   output logic [7:0]        video_color,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [RAM_AW:0]   cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   output logic              busy
);
   typedef enum logic [1:0] {CLEAR, IDLE, CPU_GO, CPU_DONE} state_t;
   state_t state, state_n;
   logic [RAM_AW-1:0] clr_cnt, w_addr;
   logic              pend, b_we;
   logic [RAM_AW:0]   b_addr;
   logic [7:0]        b_din, w_char, w_color, char_q, color_q;
   logic              vid_d, vid_clr_d, clearing, cpu_go, char_we, color_we;
   logic [7:0]        char_mem  [2**RAM_AW];
   logic [7:0]        color_mem [2**RAM_AW];
   always_comb begin
      clearing = state == CLEAR;
      cpu_go   = state == CPU_GO && !vid_req;
      char_we  = clearing || (cpu_go && b_we && !b_addr[RAM_AW]);
      color_we = clearing || (cpu_go && b_we && b_addr[RAM_AW]);
      w_addr   = clearing ? clr_cnt : b_addr[RAM_AW-1:0];
      w_char   = clearing ? CLEAR_CHAR : b_din;
      w_color  = clearing ? CLEAR_COLOR : b_din;
      busy     = state != IDLE || pend;
      state_n  = state == CLEAR  ? (&clr_cnt ? IDLE : CLEAR) :
                 state == IDLE   ? (pend && !vid_req ? CPU_GO : IDLE) :
                 state == CPU_GO ? (vid_req ? CPU_GO : CPU_DONE) : IDLE;
   end
   // Video owns the port whenever it asks; the clear sweep never overlaps a fetch.
   always_ff @(posedge clk_sys) begin
      if (char_we) char_mem[w_addr] <= w_char;
      if (color_we) color_mem[w_addr] <= w_color;
      if (vid_req && !clearing) begin
         char_q  <= char_mem[video_addr];
         color_q <= color_mem[video_addr];
      end
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= CLEAR;
         clr_cnt     <= '0;
         pend        <= 1'b0;
         b_we        <= 1'b0;
         b_addr      <= '0;
         b_din       <= '0;
         vid_d       <= 1'b0;
         vid_clr_d   <= 1'b0;
         video_data  <= CLEAR_CHAR;
         video_color <= CLEAR_COLOR;
         cpu_dout    <= '0;
         cpu_ack     <= 1'b0;
      end else begin
         state     <= state_n;
         clr_cnt   <= clearing ? clr_cnt + 1'b1 : '0;
         vid_d     <= vid_req;
         vid_clr_d <= clearing;
         if (vid_d) begin
            video_data  <= vid_clr_d ? CLEAR_CHAR : char_q;
            video_color <= vid_clr_d ? CLEAR_COLOR : color_q;
         end
         cpu_ack <= cpu_go;
         if (cpu_go && !b_we)
            cpu_dout <= b_addr[RAM_AW] ? color_mem[b_addr[RAM_AW-1:0]] : char_mem[b_addr[RAM_AW-1:0]];
         // Requests arriving while the buffer is occupied are dropped, not queued.
         if (state == CPU_DONE)
            pend <= 1'b0;
         else if (cpu_req && !pend) begin
            pend   <= 1'b1;
            b_we   <= cpu_we;
            b_addr <= cpu_addr;
            b_din  <= cpu_din;
         end
      end
   end
endmodule

// File: tb/tb_aquarius_vram.sv
// tb_aquarius_vram: directed table plus random traffic against a transaction-level model.
module tb_aquarius_vram;
   localparam logic [7:0] CC = 8'h20, CL = 8'h70;
   logic        clk_sys = 0, reset = 1, vid_req = 0, cpu_req = 0, cpu_we = 0;
   logic [9:0]  video_addr = '0;
   logic [10:0] cpu_addr = '0;
   logic [7:0]  cpu_din = '0;
   logic [7:0]  video_data, video_color, cpu_dout;
   logic        cpu_ack, busy;

   aquarius_vram dut (
      .clk_sys(clk_sys), .reset(reset), .vid_req(vid_req), .video_addr(video_addr),
      .video_data(video_data), .video_color(video_color), .cpu_req(cpu_req),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   int pass_n = 0, tot_n = 0;

   // Model: memory contents plus a count of free (non-video, post-clear) cycles
   // a buffered CPU request still needs: one to be granted, one to access.
   logic [7:0]  mc [1024];
   logic [7:0]  mo [1024];
   int          k, m_need;
   bit          v1, m_ack, m_pend, m_we;
   logic [7:0]  v1c, v1o, m_vd, m_vc, m_dout, m_din;
   logic [10:0] m_addr;

   typedef struct {
      int          kind;   // 0 write, 1 read, 2 video fetch
      logic [10:0] addr;
      logic [7:0]  din;
      int          vid_n;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      int          exp_lat;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) begin
         mc[i] = CC;
         mo[i] = CL;
      end
      k = 0; v1 = 0; m_vd = CC; m_vc = CL; m_dout = '0;
      m_ack = 0; m_pend = 0; m_need = 0;
   endtask

   task automatic tick();
      bit prev_ack, cap;
      @(posedge clk_sys);
      prev_ack = m_ack;
      cap = cpu_req && !m_pend;
      if (v1) begin
         m_vd = v1c;
         m_vc = v1o;
      end
      v1 = vid_req;
      if (vid_req) begin
         v1c = k < 1024 ? CC : mc[video_addr];
         v1o = k < 1024 ? CL : mo[video_addr];
      end
      m_ack = 0;
      if (m_pend && !prev_ack && k >= 1024 && !vid_req) begin
         m_need--;
         if (m_need == 0) begin
            m_ack = 1;
            if (m_we && m_addr[10]) mo[m_addr[9:0]] = m_din;
            else if (m_we) mc[m_addr[9:0]] = m_din;
            else m_dout = m_addr[10] ? mo[m_addr[9:0]] : mc[m_addr[9:0]];
         end
      end
      if (prev_ack) m_pend = 0;
      if (cap) begin
         m_pend = 1; m_need = 2; m_we = cpu_we; m_addr = cpu_addr; m_din = cpu_din;
      end
      k++;
      #1;
      vid_req = 0;
      cpu_req = 0;
      check("video_data", video_data, m_vd);
      check("video_color", video_color, m_vc);
      check("cpu_dout", cpu_dout, m_dout);
      check("cpu_ack", cpu_ack, m_ack);
      check("busy", busy, (k < 1024) || m_pend);
   endtask

   task automatic do_reset();
      reset = 1; vid_req = 0; cpu_req = 0;
      @(posedge clk_sys);
      #1;
      check("rst_video_data", video_data, CC);
      check("rst_video_color", video_color, CL);
      check("rst_cpu_dout", cpu_dout, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_busy", busy, 1);
      @(negedge clk_sys);
      reset = 0;
      model_reset();
   endtask

   task automatic wait_clear();
      int n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      check("clear_len", n, 1024);
   endtask

   task automatic vid_check(input logic [9:0] a, input logic [7:0] ea, input logic [7:0] eb);
      vid_req = 1;
      video_addr = a;
      tick();
      tick();
      check("fetch_char", video_data, ea);
      check("fetch_color", video_color, eb);
   endtask

   task automatic cpu_op(input vec_t v);
      int lat = 0;
      cpu_req = 1; cpu_we = v.kind == 0; cpu_addr = v.addr; cpu_din = v.din;
      video_addr = 10'h0;
      do begin
         vid_req = lat < v.vid_n;
         tick();
         lat++;
      end while (!cpu_ack && lat < 30);
      check("ack_latency", lat, v.exp_lat);
      if (v.kind == 1) check("read_data", cpu_dout, v.exp_a);
   endtask

   initial begin
      vecs[0] = '{2, 11'h155, 8'h00, 0, 8'h20, 8'h70, 0};
      vecs[1] = '{0, 11'h005, 8'h41, 0, 8'h00, 8'h00, 3};
      vecs[2] = '{0, 11'h405, 8'h16, 0, 8'h00, 8'h00, 3};
      vecs[3] = '{2, 11'h005, 8'h00, 0, 8'h41, 8'h16, 0};
      vecs[4] = '{1, 11'h005, 8'h00, 0, 8'h41, 8'h00, 3};
      vecs[5] = '{1, 11'h405, 8'h00, 3, 8'h16, 8'h00, 5};

      do_reset();
      wait_clear();
      foreach (vecs[i]) begin
         if (vecs[i].kind == 2) vid_check(vecs[i].addr[9:0], vecs[i].exp_a, vecs[i].exp_b);
         else cpu_op(vecs[i]);
         tick();
      end

      for (int i = 0; i < 1500; i++) begin
         vid_req = $urandom_range(0, 2) == 0;
         video_addr = 10'($urandom_range(0, 15));
         cpu_req = $urandom_range(0, 3) == 0;
         cpu_we = $urandom_range(0, 1) == 1;
         cpu_addr = {1'($urandom_range(0, 1)), 6'h0, 4'($urandom_range(0, 15))};
         cpu_din = 8'($urandom);
         tick();
      end
      while (m_pend) tick();

      // CPU write buffered during the clear sweep lands after it.
      do_reset();
      for (int i = 0; i < 100; i++) tick();
      begin
         int lat = 0;
         cpu_req = 1; cpu_we = 1; cpu_addr = 11'h3FF; cpu_din = 8'hAA;
         do begin
            if (lat == 50) begin
               vid_req = 1;
               video_addr = 10'h3FF;
            end
            tick();
            lat++;
         end while (!cpu_ack && lat < 1200);
         check("clear_write_ack", lat, 926);
      end
      tick();
      vid_check(10'h3FF, 8'hAA, CL);

      // Reset in the middle of a granted CPU access.
      cpu_req = 1; cpu_we = 1; cpu_addr = 11'h005; cpu_din = 8'h55;
      tick();
      tick();
      reset = 1;
      #1;
      check("midreset_ack", cpu_ack, 0);
      check("midreset_busy", busy, 1);
      @(posedge clk_sys);
      @(negedge clk_sys);
      reset = 0;
      model_reset();
      wait_clear();
      vid_check(10'h005, CC, CL);

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
